// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: 8:1 serializer behind the phy_tx lane mux.
// Sends one bit per clk_32f cycle, MSB first. The block sends a preamble of
// SYNC_WORDS comma words after reset. After that it sends data_in when valid_in
// is high, and the comma when it is low, so the line never idles.
//
// state     | meaning
// ST_SYNC   | sending the alignment preamble; every load takes IDLE_WORD
// ST_ACTIVE | preamble done; each load takes data_in if valid_in, else IDLE_WORD
module paralelo_serial_tx #(
    parameter logic [7:0]  IDLE_WORD  = 8'hBC,
    parameter int unsigned SYNC_WORDS = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       load_strobe,
    output logic       active
);

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Value of sync_cnt at the load edge that loads the final preamble comma.
    localparam logic [3:0] SYNC_LAST = 4'(SYNC_WORDS - 1);

    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    state_t     state_q, state_d;
    logic [3:0] sync_cnt_q, sync_cnt_d;
    logic       active_q, active_d;
    logic       load_strobe_q, load_strobe_d;
    logic       load;

    // Next-state logic: free-running bit counter, load or shift, preamble sequencing.
    always_comb begin
        cnt_d         = cnt_q + 3'd1;
        shift_d       = {shift_q[6:0], 1'b0};
        state_d       = state_q;
        sync_cnt_d    = sync_cnt_q;
        load          = (cnt_q == 3'd7);
        if (load) begin
            if (state_q == ST_SYNC) begin
                shift_d    = IDLE_WORD;
                sync_cnt_d = sync_cnt_q + 4'd1;
                if (sync_cnt_q == SYNC_LAST) begin
                    state_d = ST_ACTIVE;
                end
            end else begin
                // An explicit mux keeps X on data_in from reaching the line when valid_in is low.
                shift_d = valid_in ? data_in : IDLE_WORD;
            end
        end
        // The outputs come from flops. They are computed one cycle early from the next state.
        active_d      = (state_d == ST_ACTIVE);
        load_strobe_d = (cnt_d == 3'd7) && (state_d == ST_ACTIVE);
    end

    // Register stage with synchronous active-high reset.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            cnt_q         <= 3'd0;
            shift_q       <= 8'h00;
            state_q       <= ST_SYNC;
            sync_cnt_q    <= 4'd0;
            active_q      <= 1'b0;
            load_strobe_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            state_q       <= state_d;
            sync_cnt_q    <= sync_cnt_d;
            active_q      <= active_d;
            load_strobe_q <= load_strobe_d;
        end
    end

    assign data_out    = shift_q[7];
    assign load_strobe = load_strobe_q;
    assign active      = active_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx. Expected bit streams are written by hand.
// dut0 uses the default parameters. dut1 uses SYNC_WORDS=1.
module tb_paralelo_serial_tx;

    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;

    logic data_out0, load_strobe0, active0;
    logic data_out1, load_strobe1, active1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    paralelo_serial_tx dut0 (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out    (data_out0),
        .load_strobe (load_strobe0),
        .active      (active0)
    );

    paralelo_serial_tx #(.IDLE_WORD(8'hBC), .SYNC_WORDS(1)) dut1 (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out    (data_out1),
        .load_strobe (load_strobe1),
        .active      (active1)
    );

    always #5 clk_32f = ~clk_32f;

    // Move to the next cycle and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_32f);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, got, exp);
        end
    endtask

    // Hold reset for n edges, check the reset values, then release (this cycle becomes cycle 0).
    task automatic do_reset(input int n);
        reset    = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (n) step();
        chk("rst_data_out", data_out0, 1'b0);
        chk("rst_active", active0, 1'b0);
        chk("rst_strobe", load_strobe0, 1'b0);
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Cycles 0..39 after release for dut0. At the cycle-39 strobe, present the given word.
    task automatic sync_seq(input logic [7:0] nd, input logic nv);
        logic [7:0] w;
        w = COMMA;
        for (int c = 0; c < 40; c++) begin
            chk("sync_data", data_out0, (c < 8) ? 1'b0 : w[7 - (c % 8)]);
            chk("sync_active", active0, (c >= 32) ? 1'b1 : 1'b0);
            chk("sync_strobe", load_strobe0, (c == 39) ? 1'b1 : 1'b0);
            if (c == 39) begin
                data_in  = nd;
                valid_in = nv;
            end
            step();
        end
    endtask

    // Check one word on dut0 starting at cnt==0. At the strobe, present the next word.
    // When tog is set, the inputs are scrambled in the non-strobe cycles.
    task automatic word(input string tag, input logic [7:0] exp_w,
                        input logic [7:0] nd, input logic nv, input logic tog);
        for (int i = 0; i < 8; i++) begin
            chk(tag, data_out0, exp_w[7 - i]);
            chk({tag, "_active"}, active0, 1'b1);
            chk({tag, "_strobe"}, load_strobe0, (i == 7) ? 1'b1 : 1'b0);
            if (i == 7) begin
                data_in  = nd;
                valid_in = nv;
            end else if (tog) begin
                data_in  = 8'($urandom);
                valid_in = 1'($urandom);
            end
            step();
        end
    endtask

    initial begin
        logic [7:0] w;

        // Test 1: preamble after a 3-cycle reset. The strobe at cycle 39 carries A5 (test 2).
        do_reset(3);
        sync_seq(8'hA5, 1'b1);
        // Test 2 and test 3: A5, then back-to-back 01, FF, 00.
        word("w_a5", 8'hA5, 8'h01, 1'b1, 1'b0);
        word("w_01", 8'h01, 8'hFF, 1'b1, 1'b0);
        word("w_ff", 8'hFF, 8'h00, 1'b1, 1'b0);
        word("w_00", 8'h00, 8'h3C, 1'b0, 1'b0);
        // Test 4: the idle strobe gives a comma, and toggles between strobes are ignored.
        word("w_idle", COMMA, 8'hBC, 1'b1, 1'b1);
        // A valid word equal to the comma is sent unchanged. Next, X data with valid low.
        word("w_bc", COMMA, 8'hxx, 1'b0, 1'b1);
        word("w_xidle", COMMA, 8'h00, 1'b0, 1'b0);

        // Test 5: reset at cycle 43 during the A5 word.
        do_reset(2);
        sync_seq(8'hA5, 1'b1);
        w = 8'hA5;
        for (int c = 40; c < 44; c++) begin
            chk("mid_data", data_out0, w[7 - (c - 40)]);
            if (c == 43) reset = 1'b1;
            step();
        end
        chk("mid_rst_data", data_out0, 1'b0);
        chk("mid_rst_active", active0, 1'b0);
        chk("mid_rst_strobe", load_strobe0, 1'b0);
        reset    = 1'b0;
        valid_in = 1'b0;
        cyc      = 0;
        sync_seq(8'h66, 1'b1);
        word("w_66", 8'h66, 8'h00, 1'b0, 1'b0);

        // Test 6: SYNC_WORDS=1 on dut1.
        do_reset(3);
        w = COMMA;
        for (int c = 0; c < 16; c++) begin
            chk("s1_data", data_out1, (c < 8) ? 1'b0 : w[7 - (c % 8)]);
            chk("s1_active", active1, (c >= 8) ? 1'b1 : 1'b0);
            chk("s1_strobe", load_strobe1, (c == 15) ? 1'b1 : 1'b0);
            if (c == 15) begin
                data_in  = 8'h5A;
                valid_in = 1'b1;
            end
            step();
        end
        valid_in = 1'b0;
        w = 8'h5A;
        for (int c = 16; c < 24; c++) begin
            chk("s1_word", data_out1, w[7 - (c - 16)]);
            chk("s1_strobe2", load_strobe1, (c == 23) ? 1'b1 : 1'b0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
